// File: rtl/clint_irq_if.sv
// clint_irq word bus between the MEM stage and the interruptor.
// One read or write strobe per cycle; read data arrives one cycle later.
interface clint_irq_if #(
  parameter int ADDR_W = 16
);
  logic              we_i;
  logic              re_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic [31:0]       rdata_o;

  modport master (
    output we_i,
    output re_i,
    output addr_i,
    output wdata_i,
    input  rdata_o
  );

  modport slave (
    input  we_i,
    input  re_i,
    input  addr_i,
    input  wdata_i,
    output rdata_o
  );
endinterface

// File: rtl/clint_irq.sv
// clint_irq: machine timer, msip and external irq capture feeding the CSR trap.
// Define CLINT_EXT_SYNC_EN to pass ext_irq_i through a two-flop synchronizer.
module clint_irq #(
  parameter int TICK_DIV = 1,
  parameter int ADDR_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  clint_irq_if.slave  bus,
  input  logic        ext_irq_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  input  logic        irq_ack_i,
  output logic        irq_req_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] mip_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    SRC_MEI,
    SRC_MSI,
    SRC_MTI
  } src_t;

  localparam logic [ADDR_W-1:0] A_MSIP = ADDR_W'(32'h0000);
  localparam logic [ADDR_W-1:0] A_CMPL = ADDR_W'(32'h4000);
  localparam logic [ADDR_W-1:0] A_CMPH = ADDR_W'(32'h4004);
  localparam logic [ADDR_W-1:0] A_TIML = ADDR_W'(32'hBFF8);
  localparam logic [ADDR_W-1:0] A_TIMH = ADDR_W'(32'hBFFC);

  localparam logic [15:0] PMAX = 16'(TICK_DIV - 1);

  localparam logic [31:0] C_MEI = 32'h8000_000B;
  localparam logic [31:0] C_MSI = 32'h8000_0003;
  localparam logic [31:0] C_MTI = 32'h8000_0007;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic [15:0] presc;
  logic [31:0] rdata_q;
  logic [31:0] rd_mux;

  logic sel_msip;
  logic sel_cmpl;
  logic sel_cmph;
  logic sel_timl;
  logic sel_timh;
  logic tick;

  assign sel_msip = (bus.addr_i == A_MSIP);
  assign sel_cmpl = (bus.addr_i == A_CMPL);
  assign sel_cmph = (bus.addr_i == A_CMPH);
  assign sel_timl = (bus.addr_i == A_TIML);
  assign sel_timh = (bus.addr_i == A_TIMH);
  assign tick     = (presc == PMAX);

  // A bus write to mtime overrides the tick and restarts the prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime    <= '0;
      mtimecmp <= '1;
      msip     <= 1'b0;
      presc    <= '0;
    end else begin
      if (bus.we_i && sel_msip)
        msip <= bus.wdata_i[0];
      if (bus.we_i && sel_cmpl)
        mtimecmp[31:0] <= bus.wdata_i;
      if (bus.we_i && sel_cmph)
        mtimecmp[63:32] <= bus.wdata_i;
      if (bus.we_i && (sel_timl || sel_timh)) begin
        presc <= '0;
        if (sel_timl)
          mtime[31:0] <= bus.wdata_i;
        if (sel_timh)
          mtime[63:32] <= bus.wdata_i;
      end else if (tick) begin
        presc <= '0;
        mtime <= mtime + 64'd1;
      end else begin
        presc <= presc + 16'd1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_msip: rd_mux = {31'b0, msip};
      sel_cmpl: rd_mux = mtimecmp[31:0];
      sel_cmph: rd_mux = mtimecmp[63:32];
      sel_timl: rd_mux = mtime[31:0];
      sel_timh: rd_mux = mtime[63:32];
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      rdata_q <= '0;
    else if (bus.re_i)
      rdata_q <= rd_mux;
  end

  assign bus.rdata_o = rdata_q;

  logic meip;

`ifdef CLINT_EXT_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst)
      sync_q <= '0;
    else
      sync_q <= {sync_q[0], ext_irq_i};
  end

  assign meip = sync_q[1];
`else
  assign meip = ext_irq_i;
`endif

  logic mtip;
  logic gie;
  logic en_mei;
  logic en_msi;
  logic en_mti;

  assign mtip   = (mtime >= mtimecmp);
  assign gie    = mstatus_i[3];
  assign en_mei = meip & mie_i[11];
  assign en_msi = msip & mie_i[3];
  assign en_mti = mtip & mie_i[7];

  assign mip_o = {20'b0, meip, 3'b0,
                  mtip, 3'b0, msip, 3'b0};

  state_t      state;
  state_t      state_n;
  src_t        src_q;
  src_t        src_n;
  logic        req_q;
  logic        req_n;
  logic [31:0] exc_q;
  logic [31:0] exc_n;
  logic        src_live;

  always_comb begin
    src_live = 1'b0;
    unique case (src_q)
      SRC_MEI: src_live = en_mei;
      SRC_MSI: src_live = en_msi;
      SRC_MTI: src_live = en_mti;
      default: src_live = 1'b0;
    endcase
  end

  // REQ holds its latched code; ack beats a same-cycle drop.
  always_comb begin
    state_n = state;
    src_n   = src_q;
    req_n   = req_q;
    exc_n   = exc_q;
    unique case (state)
      IDLE: begin
        if (gie && (en_mei || en_msi || en_mti)) begin
          state_n = REQ;
          req_n   = 1'b1;
          if (en_mei) begin
            src_n = SRC_MEI;
            exc_n = C_MEI;
          end else if (en_msi) begin
            src_n = SRC_MSI;
            exc_n = C_MSI;
          end else begin
            src_n = SRC_MTI;
            exc_n = C_MTI;
          end
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          state_n = HOLD;
          req_n   = 1'b0;
          exc_n   = '0;
        end else if (!gie || !src_live) begin
          state_n = IDLE;
          req_n   = 1'b0;
          exc_n   = '0;
        end
      end
      HOLD: begin
        req_n = 1'b0;
        exc_n = '0;
        if (!gie)
          state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        req_n   = 1'b0;
        exc_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      src_q <= SRC_MEI;
      req_q <= 1'b0;
      exc_q <= '0;
    end else begin
      state <= state_n;
      src_q <= src_n;
      req_q <= req_n;
      exc_q <= exc_n;
    end
  end

  assign irq_req_o    = req_q;
  assign excepttype_o = exc_q;

  logic unused_bits;
  assign unused_bits = ^{mstatus_i[31:4],
                         mstatus_i[2:0],
                         mie_i[31:12],
                         mie_i[10:8],
                         mie_i[6:4],
                         mie_i[2:0]};

endmodule

// File: tb/tb_clint_irq.sv
// tb_clint_irq: scoreboard bench for clint_irq with TICK_DIV = 4.
// Expected reads and trap codes are queued at stimulus and popped on output.
module tb_clint_irq;
  localparam int TDIV = 4;
  localparam int AW   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_irq;
  logic        ack;
  logic [31:0] mstatus;
  logic [31:0] mie;
  logic        req;
  logic [31:0] exc;
  logic [31:0] mip;

  clint_irq_if #(.ADDR_W(AW)) bus ();

  clint_irq #(
    .TICK_DIV(TDIV),
    .ADDR_W  (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ext_irq_i   (ext_irq),
    .mstatus_i   (mstatus),
    .mie_i       (mie),
    .irq_ack_i   (ack),
    .irq_req_o   (req),
    .excepttype_o(exc),
    .mip_o       (mip)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] a,
                        input logic [31:0] d);
    bus.we_i    = 1'b1;
    bus.addr_i  = a;
    bus.wdata_i = d;
    step();
    bus.we_i    = 1'b0;
  endtask

  task automatic bus_rd(input string tag,
                        input logic [15:0] a,
                        input logic [31:0] exp);
    sb_t e;
    sb_q.push_back('{tag, exp});
    bus.re_i   = 1'b1;
    bus.addr_i = a;
    step();
    bus.re_i   = 1'b0;
    e = sb_q.pop_front();
    chk(e.tag, bus.rdata_o, e.exp);
  endtask

  task automatic wait_req(input logic lvl,
                          input string tag);
    int n;
    n = 0;
    while (req !== lvl && n < 200) begin
      step();
      n++;
    end
    if (req !== lvl)
      chk({tag, "_timeout"}, {31'b0, req}, {31'b0, lvl});
  endtask

  task automatic expect_req(input string tag,
                            input logic [31:0] code);
    sb_t e;
    sb_q.push_back('{tag, code});
    wait_req(1'b1, tag);
    e = sb_q.pop_front();
    chk(e.tag, exc, e.exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    ext_irq     = 1'b0;
    ack         = 1'b0;
    mstatus     = '0;
    mie         = '0;
    bus.we_i    = 1'b0;
    bus.re_i    = 1'b0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    step(3);
    rst = 1'b0;

    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_exc", exc, 32'd0);
    chk("rst_mip", mip, 32'd0);
    chk("rst_rdata", bus.rdata_o, 32'd0);
    bus_rd("cmp_lo_rst", 16'h4000, 32'hFFFF_FFFF);
    bus_rd("cmp_hi_rst", 16'h4004, 32'hFFFF_FFFF);
    step();
    chk("rdata_hold", bus.rdata_o, 32'hFFFF_FFFF);
    bus_rd("msip_rst", 16'h0000, 32'd0);
    bus_rd("unmapped_rd", 16'h1234, 32'd0);

    bus_wr(16'hBFF8, 32'hFFFF_FFFE);
    bus_wr(16'hBFFC, 32'd0);
    step(8);
    bus_rd("carry_lo", 16'hBFF8, 32'd0);
    bus_rd("carry_hi", 16'hBFFC, 32'd1);

    bus_wr(16'hBFFC, 32'd0);
    bus_wr(16'hBFF8, 32'd0);
    bus_wr(16'h4004, 32'd0);
    bus_wr(16'h4000, 32'd20);
    mie     = 32'h80;
    mstatus = 32'h8;
    expect_req("mti_code", 32'h8000_0007);
    chk("mti_mip", mip, 32'h80);
    bus_rd("mti_at20", 16'hBFF8, 32'd20);
    ack     = 1'b1;
    mstatus = 32'h0;
    step();
    ack = 1'b0;
    chk("hold_req", {31'b0, req}, 32'd0);
    chk("hold_exc", exc, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_dup_req", {31'b0, req}, 32'd0);
    end
    bus_wr(16'h4004, 32'hFFFF_FFFF);
    step();
    chk("mtip_clr", mip, 32'd0);

    mie = 32'h888;
    bus_wr(16'h4000, 32'd0);
    bus_wr(16'h4004, 32'd0);
    bus_wr(16'h0000, 32'hFFFF_FFFF);
    bus_rd("msip_rd", 16'h0000, 32'd1);
    mstatus = 32'h8;
    expect_req("msi_code", 32'h8000_0003);
    ext_irq = 1'b1;
    step(4);
    chk("req_stable", exc, 32'h8000_0003);
    chk("req_held", {31'b0, req}, 32'd1);
    chk("mip_all", mip, 32'h888);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_req", {31'b0, req}, 32'd0);
    step(3);
    chk("hold_mie1", {31'b0, req}, 32'd0);
    mstatus = 32'h0;
    step();
    mstatus = 32'h8;
    expect_req("mei_code", 32'h8000_000B);

    mstatus = 32'h0;
    step();
    chk("mie_drop_req", {31'b0, req}, 32'd0);
    chk("mie_drop_exc", exc, 32'd0);
    mstatus = 32'h8;
    step();
    chk("mie_back_req", {31'b0, req}, 32'd1);
    chk("mie_back_exc", exc, 32'h8000_000B);

    ext_irq = 1'b0;
    wait_req(1'b0, "mei_drop");
    chk("mei_drop_exc", exc, 32'd0);
    expect_req("msi_again", 32'h8000_0003);

    bus_wr(16'hBFF8, 32'd100);
    step(3);
    bus_wr(16'hBFF8, 32'h1234);
    bus_rd("coll_val", 16'hBFF8, 32'h1234);
    step(2);
    bus_rd("coll_hold", 16'hBFF8, 32'h1234);
    bus_rd("coll_next", 16'hBFF8, 32'h1235);
    bus_rd("coll_hi", 16'hBFFC, 32'd0);

    bus_wr(16'h1000, 32'hDEAD_BEEF);
    bus_rd("unmapped_wr", 16'h4004, 32'd0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_req", {31'b0, req}, 32'd0);
    chk("rst2_exc", exc, 32'd0);
    chk("rst2_mip", mip, 32'd0);
    bus_rd("rst2_cmp", 16'h4000, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end
endmodule
